// File: rtl/rand_stream_pkg.sv
// Shared constants and types for the random-backpressure stream slave.
// Holds the LFSR polynomial, the default seed and the ready-FSM state encoding.
package rand_stream_pkg;

  localparam int unsigned LfsrWidth = 16;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 (feedback from bits 0,2,3,5).
  localparam logic [LfsrWidth-1:0] LfsrTaps = 16'h002D;

  localparam logic [LfsrWidth-1:0] LfsrSeedDefault = 16'hACE1;

  typedef enum logic {
    StWait,
    StReady
  } state_e;

  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] s);
    return {^(s & LfsrTaps), s[LfsrWidth-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_16.sv
// Seeded 16-bit Fibonacci LFSR that advances one step per cycle while en_i is high.
// Never reaches the all-zero lock-up state from a non-zero seed.
module lfsr_16
  import rand_stream_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = LfsrSeedDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [LfsrWidth-1:0] state_o
);

  logic [LfsrWidth-1:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rand_stream_slv.sv
// Valid/ready stream consumer with LFSR-drawn stall cycles after each accepted beat,
// beat capture and counting, and sticky checks for master-side protocol violations.
module rand_stream_slv
  import rand_stream_pkg::*;
#(
  parameter type                   data_t          = logic,
  parameter int unsigned           MIN_WAIT_CYCLES = 0,
  parameter int unsigned           MAX_WAIT_CYCLES = 0,
  parameter logic [LfsrWidth-1:0]  LFSR_SEED       = LfsrSeedDefault,
  parameter int unsigned           CNT_WIDTH       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  data_t                data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 clr_i,
  output data_t                data_o,
  output logic                 data_valid_o,
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic                 err_drop_o,
  output logic                 err_stable_o
);

  localparam int unsigned WaitRange = MAX_WAIT_CYCLES - MIN_WAIT_CYCLES + 1;
  localparam int unsigned CntW      = (MAX_WAIT_CYCLES > 0) ? $clog2(MAX_WAIT_CYCLES + 1) : 1;

  typedef logic [CntW-1:0] cnt_t;

  if (MAX_WAIT_CYCLES < MIN_WAIT_CYCLES) begin : gen_bad_range
    $error("rand_stream_slv: MAX_WAIT_CYCLES must not be less than MIN_WAIT_CYCLES");
  end

  if (LFSR_SEED == '0) begin : gen_bad_seed
    $error("rand_stream_slv: LFSR_SEED must be non-zero");
  end

  logic                 hs;
  logic [LfsrWidth-1:0] lfsr;
  logic [31:0]          draw;

  state_e state_d, state_q;
  cnt_t   cnt_d, cnt_q;

  data_t                cap_q;
  logic                 cap_valid_q;
  logic [CNT_WIDTH-1:0] beat_cnt_d, beat_cnt_q;
  logic                 err_drop_d, err_drop_q;
  logic                 err_stable_d, err_stable_q;
  logic                 pend_q;
  data_t                data_prev_q;

  assign ready_o = (state_q == StReady);
  assign hs      = valid_i & ready_o;

  // The stall sequence depends only on the handshake count, not on master timing.
  lfsr_16 #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (hs),
    .state_o (lfsr)
  );

  assign draw = MIN_WAIT_CYCLES + (32'(lfsr) % WaitRange);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StReady: begin
        // The cycle spent leaving StWait counts as one stall, hence draw-1.
        if (hs && (draw != '0)) begin
          state_d = StWait;
          cnt_d   = cnt_t'(draw - 32'd1);
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StWait;
      cnt_q   <= cnt_t'(MIN_WAIT_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    err_drop_d   = err_drop_q;
    err_stable_d = err_stable_q;
    if (hs) begin
      beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
    end
    if (pend_q && !valid_i) begin
      err_drop_d = 1'b1;
    end
    if (pend_q && valid_i && (data_i != data_prev_q)) begin
      err_stable_d = 1'b1;
    end
    if (clr_i) begin
      beat_cnt_d   = '0;
      err_drop_d   = 1'b0;
      err_stable_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_q        <= '0;
      cap_valid_q  <= 1'b0;
      beat_cnt_q   <= '0;
      err_drop_q   <= 1'b0;
      err_stable_q <= 1'b0;
      pend_q       <= 1'b0;
      data_prev_q  <= '0;
    end else begin
      cap_valid_q  <= hs;
      if (hs) begin
        cap_q <= data_i;
      end
      beat_cnt_q   <= beat_cnt_d;
      err_drop_q   <= err_drop_d;
      err_stable_q <= err_stable_d;
      pend_q       <= valid_i & ~ready_o;
      data_prev_q  <= data_i;
    end
  end

  assign data_o       = cap_q;
  assign data_valid_o = cap_valid_q;
  assign beat_cnt_o   = beat_cnt_q;
  assign err_drop_o   = err_drop_q;
  assign err_stable_o = err_stable_q;

endmodule

// File: tb/tb_rand_stream_slv.sv
// Self-checking bench for rand_stream_slv: three instances (no stall, fixed stall,
// random stall) exercised in turn against expectations computed from the stall rules.
module tb_rand_stream_slv;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u0: MIN=MAX=0, 4-bit counter
  logic       v0, clr0, r0, dv0, ed0, es0;
  logic [7:0] d0, q0;
  logic [3:0] c0;
  // u3: MIN=MAX=3
  logic        v3, clr3, r3, dv3, ed3, es3;
  logic [7:0]  d3, q3;
  logic [31:0] c3;
  // ur: MIN=1, MAX=4
  logic        vr, clrr, rr, dvr, edr, esr;
  logic [31:0] dr, qr, cr;

  rand_stream_slv #(
    .data_t          (logic [7:0]),
    .MIN_WAIT_CYCLES (0),
    .MAX_WAIT_CYCLES (0),
    .CNT_WIDTH       (4)
  ) u0 (
    .clk_i (clk), .rst_ni (rst_n), .data_i (d0), .valid_i (v0), .ready_o (r0),
    .clr_i (clr0), .data_o (q0), .data_valid_o (dv0), .beat_cnt_o (c0),
    .err_drop_o (ed0), .err_stable_o (es0)
  );

  rand_stream_slv #(
    .data_t          (logic [7:0]),
    .MIN_WAIT_CYCLES (3),
    .MAX_WAIT_CYCLES (3)
  ) u3 (
    .clk_i (clk), .rst_ni (rst_n), .data_i (d3), .valid_i (v3), .ready_o (r3),
    .clr_i (clr3), .data_o (q3), .data_valid_o (dv3), .beat_cnt_o (c3),
    .err_drop_o (ed3), .err_stable_o (es3)
  );

  rand_stream_slv #(
    .data_t          (logic [31:0]),
    .MIN_WAIT_CYCLES (1),
    .MAX_WAIT_CYCLES (4),
    .LFSR_SEED       (16'hACE1)
  ) ur (
    .clk_i (clk), .rst_ni (rst_n), .data_i (dr), .valid_i (vr), .ready_o (rr),
    .clr_i (clrr), .data_o (qr), .data_valid_o (dvr), .beat_cnt_o (cr),
    .err_drop_o (edr), .err_stable_o (esr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy3();
    int n = 0;
    while (!r3 && n < 20) begin
      tick();
      n++;
    end
    check("u3_ready_wait", r3, 1);
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1, shifting right, feedback into bit 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  task automatic run_rand();
    logic [15:0] lfsr_m = 16'hACE1;
    int low_left = 0, beats = 0, cyc = 0, meas = 0, prev_w = 0, w = 0, cnt_m = 0;
    bit have_prev = 0, mv = 0, hs_m, hs_d;
    logic [31:0] md = 0, last_d = 0;
    while (beats < 100 && cyc < 3000) begin
      if (!mv) begin
        mv = ($urandom_range(0, 3) != 0);
        md = $urandom;
      end
      vr = mv;
      dr = md;
      check("ur_ready", rr, low_left == 0);
      if (!rr) begin
        meas++;
      end else begin
        if (have_prev) begin
          check("ur_stall_len", meas, prev_w);
          check("ur_stall_range", (meas >= 1) && (meas <= 4), 1);
        end
        have_prev = 0;
        meas = 0;
      end
      hs_m = mv && (low_left == 0);
      hs_d = mv && rr;
      if (hs_m) begin
        w = 1 + int'(lfsr_m % 16'd4);
        lfsr_m = lfsr_step(lfsr_m);
        low_left = w;
        cnt_m++;
        last_d = md;
        prev_w = w;
        have_prev = 1;
      end else if (low_left > 0) begin
        low_left--;
      end
      tick();
      if (hs_d) begin
        mv = 0;
        beats++;
      end
      check("ur_dv", dvr, hs_m);
      if (hs_m) check("ur_data", qr, last_d);
      check("ur_cnt", cr, cnt_m);
      cyc++;
    end
    vr = 0;
    check("ur_beats", beats, 100);
  endtask

  initial begin
    int low;
    rst_n = 0;
    v0 = 0; d0 = 0; clr0 = 0;
    v3 = 0; d3 = 0; clr3 = 0;
    vr = 0; dr = 0; clrr = 0;
    #2;
    check("rst_ready", r3, 0);
    check("rst_data", q3, 0);
    check("rst_dv", dv3, 0);
    check("rst_cnt", c3, 0);
    check("rst_err_drop", ed3, 0);
    check("rst_err_stable", es3, 0);
    check("rst_ready_u0", r0, 0);
    @(posedge clk);
    #1 rst_n = 1;

    for (int e = 1; e <= 5; e++) begin
      tick();
      check("u3_ready_rise", r3, e >= 4);
    end

    // Back-to-back with no stalls
    for (int i = 1; i <= 8; i++) begin
      v0 = 1;
      d0 = 8'(i);
      check("u0_ready", r0, 1);
      tick();
      check("u0_dv", dv0, 1);
      check("u0_data", q0, i);
    end
    v0 = 0;
    tick();
    check("u0_dv_idle", dv0, 0);
    check("u0_cnt8", c0, 8);
    check("u0_data8", q0, 8'h08);
    check("u0_err_drop", ed0, 0);
    check("u0_err_stable", es0, 0);
    for (int i = 9; i <= 17; i++) begin
      v0 = 1;
      d0 = 8'(i);
      tick();
    end
    v0 = 0;
    tick();
    check("u0_cnt_wrap", c0, 1);
    v0 = 1; d0 = 8'hC3; clr0 = 1;
    tick();
    v0 = 0; clr0 = 0;
    check("u0_clr_cnt", c0, 0);
    check("u0_clr_data", q0, 8'hC3);
    check("u0_clr_dv", dv0, 1);

    run_rand();

    // Fixed 3-cycle stalls with valid held and data changed only right after acceptance
    v3 = 1; d3 = 8'h10;
    for (int b = 0; b < 4; b++) begin
      wait_rdy3();
      tick();
      check("u3_data", q3, 8'h10 + b);
      d3 = 8'(8'h11 + b);
      low = 0;
      while (!r3 && low < 10) begin
        tick();
        low++;
      end
      check("u3_stall_len", low, 3);
    end
    tick();
    v3 = 0;
    check("u3_cnt5", c3, 5);
    check("u3_no_drop", ed3, 0);
    check("u3_no_unstable", es3, 0);

    // Withdraw valid during a stall
    wait_rdy3();
    v3 = 1; d3 = 8'h21;
    tick();
    d3 = 8'hAA;
    tick();
    v3 = 0;
    tick();
    check("drop_flag", ed3, 1);
    check("drop_no_stable", es3, 0);
    clr3 = 1;
    tick();
    clr3 = 0;
    check("drop_clr", ed3, 0);
    check("drop_clr_cnt", c3, 0);

    // Change data during a stall
    wait_rdy3();
    v3 = 1; d3 = 8'h33;
    tick();
    d3 = 8'hAA;
    tick();
    d3 = 8'h55;
    tick();
    check("stable_flag", es3, 1);
    check("stable_no_drop", ed3, 0);
    wait_rdy3();
    tick();
    v3 = 0;
    check("stable_data", q3, 8'h55);
    check("stable_sticky", es3, 1);
    check("stable_drop_still0", ed3, 0);

    // Reset in the middle of a stall
    wait_rdy3();
    v3 = 1; d3 = 8'h77;
    tick();
    check("pre_rst_dv", dv3, 1);
    check("pre_rst_data", q3, 8'h77);
    tick();
    rst_n = 0;
    #1;
    check("midrst_ready", r3, 0);
    check("midrst_data", q3, 0);
    check("midrst_dv", dv3, 0);
    check("midrst_cnt", c3, 0);
    check("midrst_err_stable", es3, 0);
    check("midrst_err_drop", ed3, 0);
    check("midrst_cnt_u0", c0, 0);
    v3 = 0;
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_drop", ed3, 0);
    check("post_rst_stable", es3, 0);
    check("post_rst_ready", r3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
